// File: rtl/stream_sorter_if.sv
// Valid/ready bundle for the stream sorter:
// an input stream of keys and an output stream of sorted keys.
interface stream_sorter_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_sorter.sv
// Batch insertion sorter: fills a register array in order,
// then drains it one element per output handshake.
module stream_sorter #(
  parameter  int WIDTH   = 4,
  parameter  int DEPTH   = 8,
  parameter  int DESCEND = 0,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  stream_sorter_if.slave sif,
  output logic [CW-1:0] count
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_arr [DEPTH];

  logic [DEPTH-1:0] w_aft;
  logic [WIDTH-1:0] w_ins [DEPTH];
  logic             w_acc;
  logic             w_end;

  function automatic logic f_after(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    return (DESCEND != 0) ? (a < b) : (a > b);
  endfunction

  assign sif.in_ready  = r_in_ready;
  assign sif.out_valid = r_out_valid;
  assign sif.out_data  = r_arr[0];
  assign sif.out_last  = r_out_valid &&
                         (r_count == CW'(1));
  assign count         = r_count;

  assign w_acc = sif.in_valid && r_in_ready;
  assign w_end = sif.in_last ||
                 (r_count == CW'(DEPTH - 1));

  // Empty slots count as "after" so the
  // new key lands at the first free slot.
  always_comb begin
    w_aft = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_aft[i] = (CW'(i) >= r_count) ||
                 f_after(r_arr[i], sif.in_data);
    end
  end

  // Next array contents for an insert.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ins[i] = r_arr[i];
    end
    if (w_aft[0]) begin
      w_ins[0] = sif.in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (CW'(i) <= r_count && w_aft[i]) begin
        if (!w_aft[i-1]) begin
          w_ins[i] = sif.in_data;
        end else begin
          w_ins[i] = r_arr[i-1];
        end
      end
    end
  end

  // FILL/DRAIN controller with registered handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FILL;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_arr[i] <= '0;
      end
    end else begin
      unique case (r_state)
        FILL: begin
          r_in_ready <= 1'b1;
          if (w_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
              r_arr[i] <= w_ins[i];
            end
            r_count <= r_count + CW'(1);
            if (w_end) begin
              r_state     <= DRAIN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (sif.out_ready) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
              r_arr[i] <= r_arr[i+1];
            end
            r_arr[DEPTH-1] <= '0;
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_state     <= FILL;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sorter.sv
// Directed bench: ascending DEPTH=4 sorter
// and descending DEPTH=8 sorter.
module tb_stream_sorter;

  logic       clk;
  logic       reset;
  logic [2:0] cnta;
  logic [3:0] cntb;
  int         n_vec;
  int         n_bad;

  stream_sorter_if #(.WIDTH(4)) ifa ();
  stream_sorter_if #(.WIDTH(4)) ifb ();

  stream_sorter #(
    .WIDTH(4), .DEPTH(4), .DESCEND(0)
  ) dut_a (
    .clk(clk), .reset(reset),
    .sif(ifa), .count(cnta)
  );

  stream_sorter #(
    .WIDTH(4), .DEPTH(8), .DESCEND(1)
  ) dut_b (
    .clk(clk), .reset(reset),
    .sif(ifb), .count(cntb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  // Offer one element on port A; returns at the
  // next falling edge with in_valid still set.
  task automatic push_a(
    input logic [3:0] d,
    input logic       last
  );
    chk("a_in_ready", ifa.in_ready, 1);
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    ifa.in_last  = last;
    @(negedge clk);
  endtask

  // One DRAIN cycle on port A.
  task automatic drain_a(
    input logic       rdy,
    input logic [3:0] exp,
    input logic       elast,
    input logic [2:0] ecnt
  );
    chk("a_out_valid", ifa.out_valid, 1);
    chk("a_out_data",  ifa.out_data,  exp);
    chk("a_out_last",  ifa.out_last,  elast);
    chk("a_in_ready",  ifa.in_ready,  0);
    chk("a_count",     cnta,          ecnt);
    ifa.out_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    ifa.in_valid = 0; ifa.in_data = 0;
    ifa.in_last = 0;  ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_data = 0;
    ifb.in_last = 0;  ifb.out_ready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  ifa.in_ready,  0);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_last",  ifa.out_last,  0);
    chk("rst_out_data",  ifa.out_data,  0);
    chk("rst_count",     cnta,          0);
    chk("rst_b_count",   cntb,          0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ifa.in_ready, 1);

    // 1: full batch ascending
    push_a(4'b1111, 0);
    push_a(4'b0010, 0);
    push_a(4'b0001, 0);
    push_a(4'b0000, 1);
    ifa.in_valid = 0;
    ifa.in_last  = 0;
    ifa.out_ready = 1;
    drain_a(1, 4'b0000, 0, 4);
    drain_a(1, 4'b0001, 0, 3);
    drain_a(1, 4'b0010, 0, 2);
    drain_a(1, 4'b1111, 1, 1);
    chk("t1_done_valid", ifa.out_valid, 0);
    chk("t1_done_ready", ifa.in_ready,  1);
    chk("t1_done_count", cnta,          0);

    // 2: early in_last
    ifa.out_ready = 0;
    chk("t2_cnt0", cnta, 0);
    push_a(4'b0101, 0);
    chk("t2_cnt1", cnta, 1);
    push_a(4'b0011, 1);
    ifa.in_valid = 0;
    ifa.in_last  = 0;
    drain_a(1, 4'b0011, 0, 2);
    drain_a(1, 4'b0101, 1, 1);
    chk("t2_cnt_end", cnta,         0);
    chk("t2_ready",   ifa.in_ready, 1);

    // 3: back-pressure, duplicates,
    // in_valid held through DRAIN
    ifa.out_ready = 0;
    push_a(4'b0111, 0);
    push_a(4'b0111, 0);
    push_a(4'b0010, 0);
    push_a(4'b0111, 1);
    ifa.in_data = 4'b0000;
    ifa.in_last = 0;
    drain_a(1, 4'b0010, 0, 4);
    drain_a(0, 4'b0111, 0, 3);
    drain_a(0, 4'b0111, 0, 3);
    drain_a(1, 4'b0111, 0, 3);
    drain_a(1, 4'b0111, 0, 2);
    drain_a(1, 4'b0111, 1, 1);
    ifa.in_valid = 0;
    chk("t3_cnt_end", cnta,         0);
    chk("t3_ready",   ifa.in_ready, 1);

    // 4: descending, DEPTH=8
    ifa.out_ready = 0;
    chk("t4_ready", ifb.in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      ifb.in_valid = 1;
      ifb.in_data  = 4'(i);
      ifb.in_last  = (i == 7);
      @(negedge clk);
    end
    ifb.in_data = 4'hF;
    ifb.in_last = 0;
    chk("t4_cnt_full", cntb, 8);
    for (int i = 7; i >= 0; i--) begin
      chk("b_out_valid", ifb.out_valid, 1);
      chk("b_out_data",  ifb.out_data,  i);
      chk("b_out_last",  ifb.out_last,  i == 0);
      chk("b_count",     cntb,          i + 1);
      chk("b_in_ready",  ifb.in_ready,  0);
      ifb.out_ready = 1;
      @(negedge clk);
    end
    ifb.in_valid  = 0;
    ifb.out_ready = 0;
    chk("t4_cnt_end", cntb,          0);
    chk("t4_valid",   ifb.out_valid, 0);

    // 5: reset in mid-DRAIN
    push_a(4'b0011, 0);
    push_a(4'b0001, 0);
    push_a(4'b0100, 0);
    push_a(4'b0010, 1);
    ifa.in_valid = 0;
    ifa.in_last  = 0;
    drain_a(1, 4'b0001, 0, 4);
    drain_a(1, 4'b0010, 0, 3);
    ifa.out_ready = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_valid", ifa.out_valid, 0);
    chk("t5_count", cnta,          0);
    chk("t5_data",  ifa.out_data,  0);
    @(negedge clk);
    push_a(4'b1000, 1);
    ifa.in_valid = 0;
    ifa.in_last  = 0;
    drain_a(1, 4'b1000, 1, 1);
    chk("t5_end_valid", ifa.out_valid, 0);
    chk("t5_end_ready", ifa.in_ready,  1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
